// File: rtl/uart_tx_piso.sv
// UART transmit serializer: shifts a pre-built LSB-first frame onto tx,
// holding each bit for CLKS_PER_BIT clocks, with busy/done status.
module uart_tx_piso #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_W      = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [1:0]         parity_type,
    input  logic               stop_bits,
    input  logic               data_length,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [FRAME_W-2:0] shift_reg;
    logic [3:0]         frame_len;
    logic [3:0]         frame_len_in;
    logic [3:0]         bit_cnt;
    logic [BAUD_W-1:0]  baud_cnt;

    // Parity is present only for the odd/even encodings 01 and 10.
    assign frame_len_in = 4'd1
                        + (data_length ? 4'd8 : 4'd7)
                        + {3'b000, ^parity_type}
                        + (stop_bits ? 4'd2 : 4'd1);

    // shift_reg holds the bits still to be sent after the one on tx,
    // back-filled with ones so the line drifts toward idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            frame_len <= '0;
            shift_reg <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (send) begin
                        shift_reg <= frame_in[FRAME_W-1:1];
                        frame_len <= frame_len_in;
                        bit_cnt   <= '0;
                        baud_cnt  <= '0;
                        tx        <= frame_in[0];
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == frame_len - 4'd1) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b1, shift_reg[FRAME_W-2:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_piso.sv
// Directed self-checking bench for uart_tx_piso, using a 4-clock-per-bit
// instance for most frames and a 1-clock-per-bit instance for back-to-back sends.
module tb_uart_tx_piso;

    logic        clk;
    logic        rst;
    logic        send4;
    logic        send1;
    logic [11:0] frame_in;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        data_length;
    logic        tx4, busy4, done4;
    logic        tx1, busy1, done1;

    int checkCount;
    int errorCount;

    uart_tx_piso #(.CLKS_PER_BIT(4), .FRAME_W(12)) dut4 (
        .clk(clk), .rst(rst), .send(send4), .frame_in(frame_in),
        .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    uart_tx_piso #(.CLKS_PER_BIT(1), .FRAME_W(12)) dut1 (
        .clk(clk), .rst(rst), .send(send1), .frame_in(frame_in),
        .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected are packed as {tx, busy, done}.
    task automatic checkOutput(input string tag, input logic [2:0] observed,
                               input logic [2:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: {tx,busy,done} observed %b expected %b",
                     tag, observed, expected);
        end
    endtask

    // Pulses send on the C=4 instance; returns at the middle of acceptance cycle N.
    task automatic applyStimulus(input logic [11:0] frame, input logic [1:0] pt,
                                 input logic sb, input logic dl);
        @(negedge clk);
        frame_in    = frame;
        parity_type = pt;
        stop_bits   = sb;
        data_length = dl;
        send4       = 1'b1;
        @(negedge clk);
        send4       = 1'b0;
    endtask

    // Walks a C=4 frame cycle by cycle; disturbAt pulses send with a zeroed frame,
    // resetAt asserts rst at that cycle and expects an immediate return to idle.
    task automatic checkFrame(input string tag, input logic [11:0] bits, input int len,
                              input int disturbAt, input int resetAt);
        for (int k = 0; k < len * 4; k++) begin
            checkOutput($sformatf("%s c%0d", tag, k), {tx4, busy4, done4},
                        {bits[k/4], 1'b1, 1'b0});
            if (k == resetAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput($sformatf("%s reset", tag), {tx4, busy4, done4}, 3'b100);
                return;
            end
            if (k == disturbAt) begin
                send4    = 1'b1;
                frame_in = 12'h000;
            end else begin
                send4 = 1'b0;
            end
            @(negedge clk);
        end
        send4 = 1'b0;
        checkOutput($sformatf("%s done", tag), {tx4, busy4, done4}, 3'b101);
        @(negedge clk);
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            checkOutput($sformatf("%s idle%0d", tag, k), {tx4, busy4, done4}, 3'b100);
            @(negedge clk);
        end
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        send4       = 1'b0;
        send1       = 1'b0;
        frame_in    = 12'hFFF;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        data_length = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset dut4", {tx4, busy4, done4}, 3'b100);
        checkOutput("reset dut1", {tx1, busy1, done1}, 3'b100);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset dut4", {tx4, busy4, done4}, 3'b100);

        // 9-bit frame: 7 data, no parity, one stop.
        applyStimulus(12'hFCC, 2'b00, 1'b0, 1'b0);
        checkFrame("L9", 12'hFCC, 9, -1, -1);
        checkIdle("L9", 3);

        // 12-bit frame: 8 data 0xD6, even parity, two stops.
        applyStimulus(12'hFAC, 2'b01, 1'b1, 1'b1);
        checkFrame("L12", 12'hFAC, 12, -1, -1);
        checkIdle("L12", 2);

        // Same frame with send re-pulsed and frame_in zeroed mid-frame.
        applyStimulus(12'hFAC, 2'b01, 1'b1, 1'b1);
        checkFrame("L12dist", 12'hFAC, 12, 10, -1);
        checkIdle("L12dist", 6);

        // Reset mid-frame, then a clean 9-bit frame.
        applyStimulus(12'hFAC, 2'b01, 1'b1, 1'b1);
        checkFrame("L12rst", 12'hFAC, 12, -1, 20);
        checkIdle("L12rst", 2);
        applyStimulus(12'hFCC, 2'b00, 1'b0, 1'b0);
        checkFrame("L9after", 12'hFCC, 9, -1, -1);

        // parity_type 11 means no parity: 8 data bits 0x5A, one stop -> L=10.
        applyStimulus(12'hEB4, 2'b11, 1'b0, 1'b1);
        checkFrame("L10p11", 12'hEB4, 10, -1, -1);
        checkIdle("L10p11", 2);

        // C=1 with send held high: 9 bit cycles then one done/idle cycle, repeating.
        frame_in    = 12'hFCC;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        data_length = 1'b0;
        send1       = 1'b1;
        @(negedge clk);
        begin
            logic [11:0] pattern;
            pattern = 12'hFCC;
            for (int k = 0; k < 30; k++) begin
                if ((k % 10) < 9)
                    checkOutput($sformatf("C1 c%0d", k), {tx1, busy1, done1},
                                {pattern[k % 10], 1'b1, 1'b0});
                else
                    checkOutput($sformatf("C1 c%0d", k), {tx1, busy1, done1}, 3'b101);
                @(negedge clk);
            end
        end
        send1 = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("C1 final idle", {tx1, busy1, done1}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
